// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - programmable pulse-train generator for analyzer stimulus/loopback self-test
// Optional inverted-polarity output enabled by defining PULSE_GEN_POLARITY_EN.
module pulse_gen #(
  parameter int W_WIDTH = 8,
  parameter int W_COUNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_WIDTH-1:0] width,
  input  logic [W_WIDTH-1:0] gap,
  input  logic [W_COUNT-1:0] count,
`ifdef PULSE_GEN_POLARITY_EN
  input  logic               polarity,
`endif
  output logic               ready,
  output logic               busy,
  output logic               pulse_out,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_e;

  localparam logic [W_WIDTH-1:0] ONE_W = W_WIDTH'(1);
  localparam logic [W_COUNT-1:0] ONE_C = W_COUNT'(1);

  state_e             state_q, state_d;
  logic [W_WIDTH-1:0] cnt_q, cnt_d;
  logic [W_WIDTH-1:0] width_q, width_d;
  logic [W_WIDTH-1:0] gap_q, gap_d;
  logic [W_COUNT-1:0] left_q, left_d;
  logic               pol_q, pol_d;
  logic               ready_d, busy_d, pulse_d, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      left_q    <= '0;
      pol_q     <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      left_q    <= left_d;
      pol_q     <= pol_d;
      ready     <= ready_d;
      busy      <= busy_d;
      pulse_out <= pulse_d;
      done      <= done_d;
    end
  end

  // cnt_q counts down the cycles left in the current HIGH or LOW phase, ending at 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    left_d  = left_q;
    pol_d   = pol_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          width_d = width;
          gap_d   = (gap == '0) ? ONE_W : gap;
`ifdef PULSE_GEN_POLARITY_EN
          pol_d   = polarity;
`endif
          if (width == '0 || count == '0) begin
            state_d = FIN;
          end else begin
            state_d = HIGH;
            cnt_d   = width;
            left_d  = count;
          end
        end
      end
      HIGH: begin
        if (cnt_q == ONE_W) begin
          if (left_q > ONE_C) begin
            state_d = LOW;
            cnt_d   = gap_q;
            left_d  = left_q - ONE_C;
          end else begin
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      LOW: begin
        if (cnt_q == ONE_W) begin
          state_d = HIGH;
          cnt_d   = width_q;
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        left_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without extra latency
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == HIGH) || (state_d == LOW);
    done_d  = (state_d == FIN);
    pulse_d = (state_d == HIGH) ^ pol_d;
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - directed table-driven bench for pulse_gen
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] width, gap, count;
  logic       ready, busy, pulse_out, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_gen #(.W_WIDTH(8), .W_COUNT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .width     (width),
    .gap       (gap),
    .count     (count),
`ifdef PULSE_GEN_POLARITY_EN
    .polarity  (1'b0),
`endif
    .ready     (ready),
    .busy      (busy),
    .pulse_out (pulse_out),
    .done      (done)
  );

  typedef struct {
    int          w;
    int          g;
    int          c;
    bit          inject;
    int          len;
    int          high;
    int          npulse;
    int          maxrun;
    int          first;
    int          pat_len;
    logic [31:0] pat;
  } vec_t;

  vec_t vecs[10];
  logic wave[0:599];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, len, high, np, maxrun, run, first, prof_err;
    logic prev;
    logic [31:0] act_pat;
    @(negedge clk);
    start = 1'b1;
    width = 8'(v.w);
    gap   = 8'(v.g);
    count = 8'(v.c);
    @(posedge clk);
    #1;
    start = 1'b0;
    width = 8'($urandom);
    gap   = 8'($urandom);
    count = 8'($urandom);
    len = 0;
    prof_err = 0;
    for (k = 1; k <= 590; k++) begin
      @(negedge clk);
      if (v.inject && k == 2) begin
        start = 1'b1;
        width = 8'd9;
        gap   = 8'd0;
        count = 8'd1;
      end
      if (v.inject && k == 3) start = 1'b0;
      wave[k] = pulse_out;
      if (ready !== 1'b0) prof_err++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) prof_err++;
        len = k;
        break;
      end
      if (busy !== 1'b1) prof_err++;
    end
    if (len == 0) begin
      chk($sformatf("v%0d_done_timeout", idx), 0, 1);
      return;
    end
    high = 0; np = 0; maxrun = 0; run = 0; first = 0; prev = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (wave[i]) begin
        high++;
        run++;
        if (run > maxrun) maxrun = run;
        if (!prev) np++;
        if (first == 0) first = i;
      end else begin
        run = 0;
      end
      prev = wave[i];
    end
    chk($sformatf("v%0d_len", idx), len, v.len);
    chk($sformatf("v%0d_high", idx), high, v.high);
    chk($sformatf("v%0d_npulse", idx), np, v.npulse);
    chk($sformatf("v%0d_maxrun", idx), maxrun, v.maxrun);
    chk($sformatf("v%0d_first", idx), first, v.first);
    chk($sformatf("v%0d_busy_ready_profile_errs", idx), prof_err, 0);
    if (v.pat_len > 0) begin
      act_pat = '0;
      for (int i = 1; i <= v.pat_len; i++) act_pat = {act_pat[30:0], wave[i]};
      chk($sformatf("v%0d_pattern", idx), int'(act_pat), int'(v.pat));
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", idx), int'(ready), 1);
    chk($sformatf("v%0d_done_one_cycle", idx), int'(done), 0);
  endtask

  initial begin
    int dones, highs;
    vecs[0] = '{5,   0, 1,   1'b0, 6,   5,   1,   5,   1, 5,  32'b11111};
    vecs[1] = '{3,   2, 4,   1'b0, 19,  12,  4,   3,   1, 18, 32'b111001110011100111};
    vecs[2] = '{2,   0, 3,   1'b0, 9,   6,   3,   2,   1, 8,  32'b11011011};
    vecs[3] = '{0,   3, 7,   1'b0, 1,   0,   0,   0,   0, 0,  32'b0};
    vecs[4] = '{4,   1, 0,   1'b0, 1,   0,   0,   0,   0, 0,  32'b0};
    vecs[5] = '{255, 0, 1,   1'b0, 256, 255, 1,   255, 1, 0,  32'b0};
    vecs[6] = '{1,   0, 3,   1'b0, 6,   3,   3,   1,   1, 5,  32'b10101};
    vecs[7] = '{4,   1, 2,   1'b1, 10,  8,   2,   4,   1, 9,  32'b111101111};
    vecs[8] = '{9,   0, 1,   1'b0, 10,  9,   1,   9,   1, 9,  32'b111111111};
    vecs[9] = '{1,   1, 255, 1'b0, 510, 255, 255, 1,   1, 0,  32'b0};

    rst = 1'b1; start = 1'b0; width = '0; gap = '0; count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulse", int'(pulse_out), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // abort a train during its second pulse (high cycles 15..24)
    @(negedge clk);
    start = 1'b1; width = 8'd10; gap = 8'd4; count = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_pre_pulse", int'(pulse_out), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_pulse", int'(pulse_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0; highs = 0;
    repeat (45) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (pulse_out === 1'b1) highs++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_no_pulse", highs, 0);

    run_vec(vecs[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
